// File: rtl/color_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : color_classifier
//  Purpose  : Periodically samples RGBC high bytes, normalises R/G/B against
//             clear with a restoring divider and publishes a colour class.
//             Optional debounce: define CLASSIFIER_STABILITY_FILTER_EN.
//  Revision : 1.0  initial release
// ============================================================================
module color_classifier #(
    parameter int SAMPLE_DIV   = 36000,
    parameter int DARK_TH      = 16,
    parameter int GRAY_MARGIN  = 24,
    parameter int STABLE_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    input  logic [7:0] clear,
    output logic [2:0] color,
    output logic       color_valid,
    output logic [7:0] norm_r,
    output logic [7:0] norm_g,
    output logic [7:0] norm_b,
    output logic       busy
);

    localparam int         c_timer_w = $clog2(SAMPLE_DIV);
    localparam logic [8:0] c_dark_th = 9'(DARK_TH);
    localparam logic [8:0] c_gray    = 9'(GRAY_MARGIN);

    localparam logic [2:0] c_cls_dark  = 3'd0;
    localparam logic [2:0] c_cls_red   = 3'd1;
    localparam logic [2:0] c_cls_green = 3'd2;
    localparam logic [2:0] c_cls_blue  = 3'd3;
    localparam logic [2:0] c_cls_white = 3'd4;

    if (SAMPLE_DIV < 64 || STABLE_COUNT < 1) begin : g_param_check
        $error("color_classifier: SAMPLE_DIV must be >= 64 and STABLE_COUNT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CAPTURE  = 3'd1,
        S_DIV      = 3'd2,
        S_CLASSIFY = 3'd3,
        S_FILTER   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [c_timer_w-1:0]   r_timer;
    logic [7:0]             r_g;
    logic [7:0]             r_b;
    logic [7:0]             r_clear;
    logic [15:0]            r_num;
    logic [7:0]             r_rem;
    logic [15:0]            r_quot;
    logic [3:0]             r_bit;
    logic [1:0]             r_ch;
    logic [7:0]             r_q_r;
    logic [7:0]             r_q_g;
    logic [7:0]             r_q_b;
    logic [2:0]             r_class;

    function automatic logic [15:0] f_scale(input logic [7:0] v);
        return {v, 8'h00} - {8'h00, v};
    endfunction

    logic w_tick;
    assign w_tick = (r_timer == c_timer_w'(SAMPLE_DIV - 1));

    // One restoring-division step; the remainder always stays below the divisor.
    logic [8:0]  w_shift;
    logic        w_ge;
    logic [7:0]  w_rem_nxt;
    logic [15:0] w_quot_nxt;
    logic [7:0]  w_sat;
    logic [15:0] w_next_num;

    assign w_shift    = {r_rem, r_num[15]};
    assign w_ge       = (w_shift >= {1'b0, r_clear});
    assign w_rem_nxt  = w_ge ? 8'(w_shift - {1'b0, r_clear}) : w_shift[7:0];
    assign w_quot_nxt = {r_quot[14:0], w_ge};
    assign w_sat      = (r_clear == 8'd0)     ? 8'd0  :
                        (|w_quot_nxt[15:8])   ? 8'hFF : w_quot_nxt[7:0];
    assign w_next_num = (r_ch == 2'd0) ? f_scale(r_g) : f_scale(r_b);

    logic [7:0] w_max;
    logic [7:0] w_min;
    logic [7:0] w_spread;
    logic [2:0] w_class;

    always_comb begin
        w_max = r_q_r;
        if (r_q_g > w_max) w_max = r_q_g;
        if (r_q_b > w_max) w_max = r_q_b;
        w_min = r_q_r;
        if (r_q_g < w_min) w_min = r_q_g;
        if (r_q_b < w_min) w_min = r_q_b;
        w_spread = w_max - w_min;

        if ({1'b0, r_clear} < c_dark_th)
            w_class = c_cls_dark;
        else if ({1'b0, w_spread} < c_gray)
            w_class = c_cls_white;
        else if (r_q_r >= r_q_g && r_q_r >= r_q_b)
            w_class = c_cls_red;
        else if (r_q_g >= r_q_b)
            w_class = c_cls_green;
        else
            w_class = c_cls_blue;
    end

    logic       w_publish;
    logic [2:0] w_color_nxt;

`ifdef CLASSIFIER_STABILITY_FILTER_EN
    localparam int                 c_cnt_w  = $clog2(STABLE_COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_stable = c_cnt_w'(STABLE_COUNT);

    logic [2:0]         r_cand;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         w_cand_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (r_class == r_cand) begin
            if (r_cnt != c_stable)
                w_cnt_nxt = r_cnt + 1'b1;
        end else begin
            w_cand_nxt = r_class;
            w_cnt_nxt  = c_cnt_w'(1);
        end
    end

    assign w_publish   = (w_cnt_nxt == c_stable) && (w_cand_nxt != color);
    assign w_color_nxt = w_cand_nxt;
`else
    assign w_publish   = (r_class != color);
    assign w_color_nxt = r_class;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_g         <= '0;
            r_b         <= '0;
            r_clear     <= '0;
            r_num       <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_bit       <= '0;
            r_ch        <= '0;
            r_q_r       <= '0;
            r_q_g       <= '0;
            r_q_b       <= '0;
            r_class     <= '0;
            color       <= '0;
            color_valid <= 1'b0;
            norm_r      <= '0;
            norm_g      <= '0;
            norm_b      <= '0;
            busy        <= 1'b0;
`ifdef CLASSIFIER_STABILITY_FILTER_EN
            r_cand      <= '0;
            r_cnt       <= '0;
`endif
        end else begin
            r_timer     <= w_tick ? '0 : r_timer + 1'b1;
            color_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state <= S_CAPTURE;
                        busy    <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // Red is scaled straight from the port in the same edge it would be latched.
                    r_g     <= green;
                    r_b     <= blue;
                    r_clear <= clear;
                    r_num   <= f_scale(red);
                    r_rem   <= '0;
                    r_quot  <= '0;
                    r_bit   <= '0;
                    r_ch    <= '0;
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    r_bit <= r_bit + 1'b1;
                    if (r_bit == 4'd15) begin
                        case (r_ch)
                            2'd0:    r_q_r <= w_sat;
                            2'd1:    r_q_g <= w_sat;
                            default: r_q_b <= w_sat;
                        endcase
                        r_rem  <= '0;
                        r_quot <= '0;
                        r_num  <= w_next_num;
                        r_ch   <= r_ch + 1'b1;
                        if (r_ch == 2'd2)
                            r_state <= S_CLASSIFY;
                    end else begin
                        r_rem  <= w_rem_nxt;
                        r_quot <= w_quot_nxt;
                        r_num  <= {r_num[14:0], 1'b0};
                    end
                end
                S_CLASSIFY: begin
                    r_class <= w_class;
                    r_state <= S_FILTER;
                end
                S_FILTER: begin
                    norm_r <= r_q_r;
                    norm_g <= r_q_g;
                    norm_b <= r_q_b;
`ifdef CLASSIFIER_STABILITY_FILTER_EN
                    r_cand <= w_cand_nxt;
                    r_cnt  <= w_cnt_nxt;
`endif
                    if (w_publish) begin
                        color       <= w_color_nxt;
                        color_valid <= 1'b1;
                    end
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_color_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_color_classifier
//  Purpose  : Scoreboard bench for color_classifier (either filter build).
//  Revision : 1.0  initial release
// ============================================================================
module tb_color_classifier;

    localparam int SD = 64;
    localparam int SC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] red = '0, green = '0, blue = '0, clear = '0;
    logic [2:0] color;
    logic       color_valid;
    logic [7:0] norm_r, norm_g, norm_b;
    logic       busy;

    color_classifier #(
        .SAMPLE_DIV  (SD),
        .DARK_TH     (16),
        .GRAY_MARGIN (24),
        .STABLE_COUNT(SC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .clear      (clear),
        .color      (color),
        .color_valid(color_valid),
        .norm_r     (norm_r),
        .norm_g     (norm_g),
        .norm_b     (norm_b),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // {timeout, busy_len, stray_valid, norm_r, norm_g, norm_b, color, color_valid}
    logic [44:0] sb[$];
    int m_cand = 0, m_cnt = 0, m_color = 0;

    function automatic int f_norm(int ch, int c);
        int q;
        if (c == 0) return 0;
        q = (ch * 255) / c;
        return (q > 255) ? 255 : q;
    endfunction

    function automatic int f_class(int nr, int ng, int nb, int c);
        int mx, mn;
        if (c < 16) return 0;
        mx = nr; if (ng > mx) mx = ng; if (nb > mx) mx = nb;
        mn = nr; if (ng < mn) mn = ng; if (nb < mn) mn = nb;
        if (mx - mn < 24) return 4;
        if (nr >= ng && nr >= nb) return 1;
        if (ng >= nb) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_cand = 0; m_cnt = 0; m_color = 0;
    endtask

    task automatic model_push(int r, int g, int b, int c);
        int nr, ng, nb, cls;
        bit v;
        nr = f_norm(r, c); ng = f_norm(g, c); nb = f_norm(b, c);
        cls = f_class(nr, ng, nb, c);
        v = 1'b0;
`ifdef CLASSIFIER_STABILITY_FILTER_EN
        if (cls == m_cand) begin
            if (m_cnt < SC) m_cnt++;
        end else begin
            m_cand = cls; m_cnt = 1;
        end
        if (m_cnt == SC && m_cand != m_color) begin
            m_color = m_cand; v = 1'b1;
        end
`else
        if (cls != m_color) begin
            m_color = cls; v = 1'b1;
        end
`endif
        sb.push_back({1'b0, 8'd51, 8'd0, 8'(nr), 8'(ng), 8'(nb), 3'(m_color), v});
    endtask

    // Entered at the first negedge with busy high; returns at the negedge busy drops.
    task automatic finish_eval(output logic [44:0] obs);
        int blen = 0, stray = 0;
        while (busy === 1'b1 && blen < 200) begin
            blen++;
            if (color_valid !== 1'b0) stray++;
            @(negedge clk);
            if (blen == 1) begin
                red = 8'($urandom); green = 8'($urandom);
                blue = 8'($urandom); clear = 8'($urandom);
            end
        end
        obs = {1'b0, 8'(blen), 8'(stray), norm_r, norm_g, norm_b, color, color_valid};
    endtask

    task automatic run_eval(int r, int g, int b, int c, output logic [44:0] obs);
        int waited = 0;
        red = 8'(r); green = 8'(g); blue = 8'(b); clear = 8'(c);
        @(negedge clk);
        while (busy !== 1'b1 && waited < 3 * SD) begin
            @(negedge clk);
            waited++;
        end
        model_push(r, g, b, c);
        if (busy !== 1'b1) obs = {1'b1, 44'd0};
        else finish_eval(obs);
    endtask

    task automatic test_reset();
        logic [44:0] obs, exp;
        int n = 0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({color, color_valid, norm_r, norm_g, norm_b, busy} !== 29'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h required 0", {color, color_valid, norm_r, norm_g, norm_b, busy});
        end
        while (n < 3 * SD) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (busy === 1'b1) break;
        end
        n_checks++;
        if (n != SD) begin
            n_errors++;
            $display("FAIL reset_first_busy: got %0d cycles required %0d", n, SD);
        end
        model_push(0, 0, 0, 0);
        finish_eval(obs);
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL reset_first_eval: got %h required %h", obs, exp);
        end
    endtask

    task automatic test_red();
        logic [44:0] obs, exp;
        for (int i = 0; i < 3; i++) begin
            run_eval(200, 40, 30, 255, obs);
            exp = sb.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL red_eval%0d: got %h required %h", i, obs, exp);
            end
        end
        n_checks++;
        if ({norm_r, norm_g, norm_b, color} !== {8'd200, 8'd40, 8'd30, 3'd1}) begin
            n_errors++;
            $display("FAIL red_final: got %h required %h", {norm_r, norm_g, norm_b, color}, {8'd200, 8'd40, 8'd30, 3'd1});
        end
    endtask

    task automatic test_steady(string name, int r, int g, int b, int c,
                               logic [23:0] want_norms, logic [2:0] want_color);
        logic [44:0] obs, exp;
        for (int i = 0; i < SC; i++) begin
            run_eval(r, g, b, c, obs);
            exp = sb.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL %s_eval%0d: got %h required %h", name, i, obs, exp);
            end
        end
        n_checks++;
        if ({norm_r, norm_g, norm_b, color} !== {want_norms, want_color}) begin
            n_errors++;
            $display("FAIL %s_final: got %h required %h", name, {norm_r, norm_g, norm_b, color}, {want_norms, want_color});
        end
    endtask

    task automatic test_flicker();
        logic [44:0] obs, exp;
        int pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) run_eval(200, 40, 30, 255, obs);
            else            run_eval(30, 200, 40, 255, obs);
            exp = sb.pop_front();
            if (obs[0] === 1'b1) pulses++;
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL flicker_eval%0d: got %h required %h", i, obs, exp);
            end
        end
        n_checks++;
`ifdef CLASSIFIER_STABILITY_FILTER_EN
        if (pulses != 0 || color !== 3'd0) begin
`else
        if (pulses != 6 || color !== 3'd2) begin
`endif
            n_errors++;
            $display("FAIL flicker_pulses: got pulses=%0d color=%0d", pulses, color);
        end
    endtask

    task automatic test_reset_mid();
        logic [44:0] obs, exp;
        int waited = 0, stray = 0;
        for (int i = 0; i < SC; i++) begin
            run_eval(200, 40, 30, 255, obs);
            exp = sb.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL midrst_pre%0d: got %h required %h", i, obs, exp);
            end
        end
        red = 8'd30; green = 8'd200; blue = 8'd40; clear = 8'd255;
        @(negedge clk);
        while (busy !== 1'b1 && waited < 3 * SD) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_start: got busy=%b required 1", busy);
        end
        repeat (19) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({color, color_valid, norm_r, norm_g, norm_b, busy} !== 29'd0) begin
            n_errors++;
            $display("FAIL midrst_outputs: got %h required 0", {color, color_valid, norm_r, norm_g, norm_b, busy});
        end
        repeat (3) begin
            @(negedge clk);
            if (color_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        rst = 1'b1;
        n_checks++;
        if (stray != 0) begin
            n_errors++;
            $display("FAIL midrst_hold: got %0d active cycles required 0", stray);
        end
        run_eval(30, 200, 40, 255, obs);
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL midrst_resume: got %h required %h", obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_red();
        test_steady("white", 100, 100, 100, 120, {8'd212, 8'd212, 8'd212}, 3'd4);
        test_steady("sat",   250,  10,  10, 100, {8'd255, 8'd25,  8'd25},  3'd1);
        test_steady("dark",   50,  50,  50,   5, {8'd255, 8'd255, 8'd255}, 3'd0);
        test_steady("div0",  120,  60,  30,   0, {8'd0,   8'd0,   8'd0},   3'd0);
        test_flicker();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
